// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Streams a burst of words out of the read port of a block RAM onto a
//   valid/ready interface. A burst is a start address and a word count. Reads
//   are issued only when the output skid FIFO is guaranteed to have room for
//   the word when it returns. Because of that, downstream stalls never drop
//   or duplicate data, even though the RAM read latency is fixed.
//
// Parameters
//   RAM_WIDTH    data word width
//   RAM_DEPTH    number of RAM entries (AW = clog2(RAM_DEPTH))
//   READ_LATENCY cycles from enb_out to valid data_in (2 = output register on)
//   FIFO_DEPTH   skid FIFO entries, must be at least READ_LATENCY+1
//
// Ports
//   clk_in        clock, also clocks the RAM read port
//   rst_in        synchronous active-high reset
//   start_in      one-cycle burst request (ignored while busy)
//   base_addr_in  first RAM address of the burst
//   length_in     number of words, 0..RAM_DEPTH
//   addr_out      RAM read address        (to addrb)
//   enb_out       RAM read enable         (to enb)
//   regceb_out    RAM output reg enable   (to regceb, tied high)
//   data_in       RAM read data           (from doutb)
//   data_out      stream data, FIFO head
//   valid_out     stream data valid
//   ready_in      downstream ready
//   last_out      head word is the final word of the burst
//   busy_out      burst in progress
//   done_out      one-cycle pulse after the last word transfers
module bram_stream_reader #(
  parameter int RAM_WIDTH    = 36,
  parameter int RAM_DEPTH    = 512,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [$clog2(RAM_DEPTH)-1:0] base_addr_in,
  input  logic [$clog2(RAM_DEPTH):0]   length_in,
  output logic [$clog2(RAM_DEPTH)-1:0] addr_out,
  output logic                         enb_out,
  output logic                         regceb_out,
  input  logic [RAM_WIDTH-1:0]         data_in,
  output logic [RAM_WIDTH-1:0]         data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         last_out,
  output logic                         busy_out,
  output logic                         done_out
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for in_flight + fifo_count + 1 in the worst case.
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

  localparam logic [AW-1:0] ADDR_MAX = AW'(RAM_DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  // Burst bookkeeping
  logic [AW-1:0]           addr_q;
  logic [AW:0]             remaining_q;
  logic                    done_q;

  // Read-latency pipeline: valid strobe plus a "this is the last word" tag
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_last;

  // Skid FIFO
  logic [RAM_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   mem_last;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count;

  // Handshake / flow-control terms
  logic                    push;
  logic                    pop;
  logic                    head_last;
  logic [CW-1:0]           in_flight;
  logic [CW-1:0]           occupancy;
  logic                    issue;
  logic                    busy;

  always_comb begin
    push      = pipe_vld[READ_LATENCY-1];
    pop       = (count != '0) && ready_in;
    head_last = mem_last[rd_ptr];
    in_flight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(pipe_vld[i]);
    end
    // Slots that would be claimed if a read were issued now. A word popped
    // this cycle frees its slot, so it offsets the new request.
    occupancy = in_flight + count + (pop ? CW'(0) : CW'(1));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_in && (length_in != '0)) begin
          state_next = READ;
        end
      end
      READ: begin
        if (issue && (remaining_q == (AW+1)'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state != IDLE);
    issue = (state == READ) && (remaining_q != '0) &&
            (occupancy <= CW'(FIFO_DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Address / length counters, latency pipeline, completion pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      pipe_vld    <= '0;
      pipe_last   <= '0;
    end else begin
      done_q <= 1'b0;

      if ((state == IDLE) && start_in) begin
        if (length_in != '0) begin
          addr_q      <= base_addr_in;
          remaining_q <= length_in;
        end else begin
          done_q <= 1'b1;
        end
      end

      if (issue) begin
        addr_q      <= (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
        remaining_q <= remaining_q - (AW+1)'(1);
      end

      if ((state == DRAIN) && pop && head_last) begin
        done_q <= 1'b1;
      end

      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (remaining_q == (AW+1)'(1));
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO. Storage is cleared on reset so data_out reads back as zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      mem_last <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr]      <= data_in;
        mem_last[wr_ptr] <= pipe_last[READ_LATENCY-1];
        wr_ptr           <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_out   = addr_q;
    enb_out    = issue;
    regceb_out = 1'b1;
    data_out   = mem[rd_ptr];
    valid_out  = (count != '0);
    last_out   = (count != '0) && head_last;
    busy_out   = busy;
    done_out   = done_q;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader
//   Directed bench for bram_stream_reader with a two-stage BRAM read model
//   (RAM[i] = i). A negedge monitor logs issued addresses, transferred words
//   and done pulses with cycle stamps. Each scenario task compares those logs
//   against hand-computed values.
module tb_bram_stream_reader;

  localparam int W  = 36;
  localparam int D  = 512;
  localparam int L  = 2;
  localparam int F  = 4;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   length_in;
  logic [AW-1:0] addr_out;
  logic          enb_out;
  logic          regceb_out;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_in;
  logic          last_out;
  logic          busy_out;
  logic          done_out;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .RAM_WIDTH(W), .RAM_DEPTH(D), .READ_LATENCY(L), .FIFO_DEPTH(F)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .length_in(length_in),
    .addr_out(addr_out), .enb_out(enb_out), .regceb_out(regceb_out),
    .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .last_out(last_out), .busy_out(busy_out),
    .done_out(done_out)
  );

  // BRAM read port, output register enabled: data two cycles after enb.
  logic [W-1:0] ram [D];
  logic [W-1:0] ram_lat = '0;
  initial data_in = '0;
  always @(posedge clk) begin
    if (enb_out) ram_lat <= ram[addr_out];
    if (regceb_out) data_in <= ram_lat;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           addr_q[$];
  int           addr_c[$];
  logic [W-1:0] dat_q[$];
  int           dat_c[$];
  bit           last_q[$];
  int           done_c[$];

  always @(negedge clk) begin
    if (enb_out) begin
      addr_q.push_back(int'(addr_out));
      addr_c.push_back(cyc);
    end
    if (valid_out && ready_in) begin
      dat_q.push_back(data_out);
      dat_c.push_back(cyc);
      last_q.push_back(last_out);
    end
    if (done_out) done_c.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;

  task automatic clear_mon();
    addr_q.delete(); addr_c.delete(); dat_q.delete();
    dat_c.delete(); last_q.delete(); done_c.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_burst(input int base, input int len, output int s);
    base_addr_in = AW'(base);
    length_in    = (AW+1)'(len);
    start_in     = 1'b1;
    step();
    s        = cyc;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_c.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b1;
    base_addr_in = '0; length_in = '0;
    repeat (3) step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_out); end
    checks++; if (enb_out !== 1'b0) begin errors++; $display("FAIL reset_enb got=%b exp=0", enb_out); end
    checks++; if (addr_out !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", addr_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got=%0d exp=0", data_out); end
    checks++; if (regceb_out !== 1'b1) begin errors++; $display("FAIL reset_regceb got=%b exp=1", regceb_out); end
    rst_in = 1'b0;
    step();
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy_out); end
  endtask

  task automatic test_basic();
    int s; bit ok;
    clear_mon();
    ready_in = 1'b1;
    start_burst(10, 4, s);
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy_out); end
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL basic_nreads got=%0d exp=4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] != 10 + i || addr_c[i] != s + i) begin
        errors++; $display("FAIL basic_addr[%0d] got=%0d@%0d exp=%0d@%0d", i, addr_q[i], addr_c[i], 10 + i, s + i);
      end
    end
    checks++; if (dat_q.size() != 4) begin errors++; $display("FAIL basic_nwords got=%0d exp=4", dat_q.size()); end
    for (int i = 0; i < 4 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== W'(10 + i) || dat_c[i] != s + 3 + i || last_q[i] != (i == 3)) begin
        errors++; $display("FAIL basic_word[%0d] got=%0d@%0d last=%b exp=%0d@%0d last=%b",
                           i, dat_q[i], dat_c[i], last_q[i], 10 + i, s + 3 + i, i == 3);
      end
    end
    checks++;
    if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != s + 7)) begin
      errors++; $display("FAIL basic_done got=%0d_pulses first@%0d exp=1@%0d",
                         done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, s + 7);
    end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy_out); end
  endtask

  task automatic test_wrap();
    int s; bit ok;
    int exp_a[4] = '{510, 511, 0, 1};
    clear_mon();
    ready_in = 1'b1;
    start_burst(510, 4, s);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    checks++;
    if (addr_q.size() != 4 || dat_q.size() != 4) begin
      errors++; $display("FAIL wrap_count got=%0d/%0d exp=4/4", addr_q.size(), dat_q.size());
    end
    for (int i = 0; i < 4 && i < addr_q.size() && i < dat_q.size(); i++) begin
      checks++;
      if (addr_q[i] != exp_a[i] || dat_q[i] !== W'(exp_a[i])) begin
        errors++; $display("FAIL wrap[%0d] got=addr%0d/data%0d exp=%0d", i, addr_q[i], dat_q[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_stall();
    int s; bit ok; bit seen;
    clear_mon();
    ready_in = 1'b0;
    start_burst(100, 8, s);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (valid_out) begin
        seen = 1'b1;
        checks++;
        if (data_out !== W'(100) || last_out !== 1'b0) begin
          errors++; $display("FAIL stall_hold cyc%0d got=%0d last=%b exp=100 last=0", i, data_out, last_out);
        end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_valid got=0 exp=1"); end
    checks++;
    if (addr_q.size() > F || addr_q.size() == 0) begin
      errors++; $display("FAIL stall_reads got=%0d exp=1..%0d", addr_q.size(), F);
    end
    ready_in = 1'b1;
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=no_done exp=done"); end
    checks++;
    if (addr_q.size() != 8 || dat_q.size() != 8) begin
      errors++; $display("FAIL stall_count got=%0d/%0d exp=8/8", addr_q.size(), dat_q.size());
    end
    for (int i = 0; i < 8 && i < addr_q.size() && i < dat_q.size(); i++) begin
      checks++;
      if (addr_q[i] != 100 + i || dat_q[i] !== W'(100 + i) || last_q[i] != (i == 7)) begin
        errors++; $display("FAIL stall_word[%0d] got=a%0d d%0d l%b exp=%0d l%b",
                           i, addr_q[i], dat_q[i], last_q[i], 100 + i, i == 7);
      end
    end
    checks++; if (done_c.size() != 1) begin errors++; $display("FAIL stall_done got=%0d exp=1", done_c.size()); end
  endtask

  task automatic test_zero_length();
    int s; int busy_hi;
    clear_mon();
    ready_in = 1'b1;
    start_burst(33, 0, s);
    busy_hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_out) busy_hi++;
      step();
    end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL zero_busy got=%0d_cycles exp=0", busy_hi); end
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL zero_enb got=%0d exp=0", addr_q.size()); end
    checks++;
    if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != s)) begin
      errors++; $display("FAIL zero_done got=%0d_pulses first@%0d exp=1@%0d",
                         done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, s);
    end
  endtask

  task automatic test_reset_mid();
    int s; bit ok; int stray;
    clear_mon();
    ready_in = 1'b1;
    start_burst(0, 16, s);
    while (cyc < s + 5) step();
    checks++; if (!(valid_out && data_out === W'(2))) begin errors++; $display("FAIL mid_third got=v%b d%0d exp=v1 d2", valid_out, data_out); end
    rst_in = 1'b1;
    step();
    checks++;
    if ({valid_out, last_out, busy_out, done_out, enb_out} !== 5'b0 || addr_out !== '0 || data_out !== '0) begin
      errors++; $display("FAIL mid_reset got=v%b l%b b%b d%b e%b a%0d data%0d exp=all0",
                         valid_out, last_out, busy_out, done_out, enb_out, addr_out, data_out);
    end
    rst_in = 1'b0;
    clear_mon();
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid_out || busy_out || enb_out) stray++;
    end
    checks++; if (stray != 0 || done_c.size() != 0) begin errors++; $display("FAIL mid_quiet got=%0d_active %0d_done exp=0 0", stray, done_c.size()); end
    clear_mon();
    start_burst(20, 3, s);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_restart_timeout got=no_done exp=done"); end
    checks++; if (dat_q.size() != 3) begin errors++; $display("FAIL mid_restart_count got=%0d exp=3", dat_q.size()); end
    for (int i = 0; i < 3 && i < dat_q.size(); i++) begin
      checks++;
      if (dat_q[i] !== W'(20 + i) || last_q[i] != (i == 2)) begin
        errors++; $display("FAIL mid_restart[%0d] got=%0d l%b exp=%0d l%b", i, dat_q[i], last_q[i], 20 + i, i == 2);
      end
    end
  endtask

  task automatic test_start_ignored();
    int s; bit ok;
    clear_mon();
    ready_in = 1'b1;
    start_burst(50, 6, s);
    step();
    base_addr_in = AW'(200); length_in = (AW+1)'(3); start_in = 1'b1;
    step();
    start_in = 1'b0;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout got=no_done exp=done"); end
    checks++;
    if (addr_q.size() != 6 || dat_q.size() != 6) begin
      errors++; $display("FAIL ignore_count got=%0d/%0d exp=6/6", addr_q.size(), dat_q.size());
    end
    for (int i = 0; i < 6 && i < addr_q.size() && i < dat_q.size(); i++) begin
      checks++;
      if (addr_q[i] != 50 + i || dat_q[i] !== W'(50 + i) || last_q[i] != (i == 5)) begin
        errors++; $display("FAIL ignore_word[%0d] got=a%0d d%0d l%b exp=%0d l%b",
                           i, addr_q[i], dat_q[i], last_q[i], 50 + i, i == 5);
      end
    end
    checks++; if (done_c.size() != 1) begin errors++; $display("FAIL ignore_done got=%0d exp=1", done_c.size()); end
  endtask

  initial begin
    for (int i = 0; i < D; i++) ram[i] = W'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_length();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
